z80_wait_mem: RTL and testbench
===============================

Name: z80_wait_mem

Overview:
Parametrised Z80-bus memory responder. It replaces the fixed, zero-wait memory model used in the top-level bench, and can also serve as an on-chip RAM/ROM window.
- Decodes MREQ_L/RD_L/WR_L/RFSH_L from the core.
- Inserts a programmable number of wait states via WAIT_L.
- Returns read data or captures write data.
- Keeps saturating access counters for bench checking.
Several instances may share the bus, each claiming its own address window.

Parameters:
ADDR_W, 16, width of addr_bus
DEPTH_LOG2, 12, log2 of storage bytes; window size = 2**DEPTH_LOG2
BASE, 16'h0000, window base address; must be aligned to window size
WAIT_CYCLES, 2, wait states inserted per access (0..15)
CNT_W, 16, width of access counters

Ports:
clk  input  1  system clock
rst_L  input  1  asynchronous active-low reset
addr_bus  input  ADDR_W  Z80 address bus
data_bus  inout  8  Z80 data bus; driven only during a selected read
MREQ_L  input  1  memory request, active low
RD_L  input  1  read strobe, active low
WR_L  input  1  write strobe, active low
RFSH_L  input  1  refresh cycle, active low
WAIT_L  output  1  wait request to core, active low
wp  input  1  write protect; 1 = writes are ignored (ROM mode)
rd_count  output  CNT_W  saturating count of completed reads
wr_count  output  CNT_W  saturating count of completed (non-protected) writes
busy  output  1  high while an access is in progress (state != IDLE)

Behaviour:
- Clock and reset: single clock clk; rst_L is asynchronous, active-low. All state updates on posedge clk.
- Reset values: state=IDLE, WAIT_L=1, data_bus=Z, rd_count=0, wr_count=0, busy=0, wait counter=0. Storage contents are not cleared by reset.
- Select condition: sel = !MREQ_L && RFSH_L && (addr_bus[ADDR_W-1:DEPTH_LOG2] == BASE[ADDR_W-1:DEPTH_LOG2]) && (!RD_L || !WR_L).
- Refresh cycles (RFSH_L=0) are never selected.
- Storage index = addr_bus[DEPTH_LOG2-1:0].
- States:
  - IDLE: on posedge with sel, latch direction (rd if !RD_L, else wr) and address. If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1; otherwise go to ACCESS.
  - WAIT: WAIT_L=0 combinationally in this state. Counter decrements each cycle; at counter==0 go to ACCESS. A WAIT_CYCLES=N access holds WAIT_L low for exactly N clocks.
  - ACCESS (one cycle), read: drive data_bus = mem[latched addr] from entry to ACCESS until exit from HOLD; increment rd_count.
  - ACCESS (one cycle), write: mem[latched addr] <= data_bus sampled this cycle unless wp=1; increment wr_count only if wp=0.
  - ACCESS exit: go to HOLD.
  - HOLD: wait for MREQ_L=1, then go to IDLE. In HOLD, a read keeps driving data_bus while RD_L=0, and stops (Z) as soon as RD_L=1, combinationally.
- Abort: if MREQ_L deasserts during WAIT, return to IDLE next cycle. WAIT_L goes to 1, no access is performed, and counters are unchanged.
- Simultaneous RD_L and WR_L low: treated as a read; the write is ignored.
- Counters saturate at all-ones and do not wrap.
- busy = (state != IDLE).
- data_bus is never driven when the access is not selected, is a write, or is in WAIT.
- Reset mid-operation (any state): immediate return to IDLE, WAIT_L=1, data_bus=Z. A pending write is dropped.
- Back-to-back accesses: a new access requires passing through IDLE with MREQ_L=1 for at least one cycle.
- Latency from select to data valid: WAIT_CYCLES+1 clocks.

Test Plan:
- Reset: hold rst_L=0 mid-WAIT -> WAIT_L=1, data_bus=Z, busy=0, counters=0, asynchronously.
- Write then read, WAIT_CYCLES=2: write 8'hA5 to 16'h0123, then read 16'h0123 -> WAIT_L low exactly 2 clocks per access; data_bus=8'hA5 three clocks after select; wr_count=1, rd_count=1.
- ROM mode: wp=1, write 8'h3C to 16'h0010 (previously 8'h00) -> read returns 8'h00, wr_count unchanged.
- Window and refresh: BASE=16'h8000, DEPTH_LOG2=12. Read at 16'h0123 -> no response, data_bus=Z, WAIT_L=1. MREQ_L=0 with RFSH_L=0 at 16'h8000 -> no response.
- Abort: deassert MREQ_L after 1 wait clock (WAIT_CYCLES=3) -> IDLE next clock, no bus drive, counters unchanged.
- Zero-wait and saturation: WAIT_CYCLES=0, CNT_W=2, five reads -> WAIT_L never low, data valid 1 clock after select, rd_count saturates at 2'b11.

Source files
------------

// File: rtl/z80_wait_mem.sv
// rtl/z80_wait_mem.sv - Z80-bus memory responder with programmable wait states and access counters
module z80_wait_mem #(
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH_LOG2  = 12,
  parameter logic [ADDR_W-1:0] BASE        = 16'h0000,
  parameter int                WAIT_CYCLES = 2,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic [ADDR_W-1:0] addr_bus,
  inout  wire  [7:0]        data_bus,
  input  logic              MREQ_L,
  input  logic              RD_L,
  input  logic              WR_L,
  input  logic              RFSH_L,
  output logic              WAIT_L,
  input  logic              wp,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Wait counter is loaded with N-1 so the WAIT state lasts exactly N clocks.
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_mem [DEPTH];
  logic                  r_is_rd;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [3:0]            r_wcnt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic                  w_sel;
  logic                  w_in_window;
  logic                  w_drive;
  logic                  w_wait_l;
  logic                  w_busy;
  logic [7:0]            w_rd_data;

  // Refresh cycles carry a row address, never a real access, so they are excluded.
  assign w_in_window = (addr_bus[ADDR_W-1:DEPTH_LOG2] == BASE[ADDR_W-1:DEPTH_LOG2]);
  assign w_sel       = !MREQ_L && RFSH_L && w_in_window && (!RD_L || !WR_L);

  // State register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; MREQ_L rising during WAIT aborts the access.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sel) begin
          w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (MREQ_L) begin
          w_next = S_IDLE;
        end else if (r_wcnt == 4'd0) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next = S_HOLD;
      end
      S_HOLD: begin
        if (MREQ_L) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Bus outputs; read data is released as soon as RD_L rises in HOLD.
  always_comb begin
    w_wait_l = 1'b1;
    w_busy   = 1'b0;
    w_drive  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
      end
      S_WAIT: begin
        w_wait_l = 1'b0;
        w_busy   = 1'b1;
      end
      S_ACCESS: begin
        w_busy  = 1'b1;
        w_drive = r_is_rd;
      end
      S_HOLD: begin
        w_busy  = 1'b1;
        w_drive = r_is_rd && !RD_L;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign WAIT_L    = w_wait_l;
  assign busy      = w_busy;
  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;
  assign w_rd_data = r_mem[r_idx];
  assign data_bus  = w_drive ? w_rd_data : 8'bz;

  // Access latch, wait countdown and saturating counters; read wins if both strobes are low.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_is_rd  <= 1'b0;
      r_idx    <= '0;
      r_wcnt   <= 4'd0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel) begin
            r_is_rd <= !RD_L;
            r_idx   <= addr_bus[DEPTH_LOG2-1:0];
            r_wcnt  <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (!MREQ_L && (r_wcnt != 4'd0)) begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (r_is_rd) begin
            if (r_rd_cnt != {CNT_W{1'b1}}) begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end else if (!wp) begin
            if (r_wr_cnt != {CNT_W{1'b1}}) begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_wcnt <= r_wcnt;
        end
      endcase
    end
  end

  // Storage write; not reset, and a write caught by reset is dropped since state is forced to IDLE.
  always_ff @(posedge clk) begin
    if (rst_L && (r_state == S_ACCESS) && !r_is_rd && !wp) begin
      r_mem[r_idx] <= data_bus;
    end
  end

endmodule

// File: tb/tb_z80_wait_mem.sv
// tb/tb_z80_wait_mem.sv - randomized self-checking bench for z80_wait_mem with three instances sharing one bus
module tb_z80_wait_mem;

  logic        clk;
  logic        rst_L;
  logic [15:0] addr;
  logic        MREQ_L, RD_L, WR_L, RFSH_L;
  tri1  [7:0]  data_bus;
  logic [7:0]  tb_d;
  logic        tb_oe;
  logic [2:0]  wait_l;
  logic [2:0]  busy_w;
  logic [2:0]  wp_v;
  logic [15:0] rd_a, wr_a, rd_b, wr_b;
  logic [1:0]  rd_c, wr_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mm [3][4096];
  bit         mv [3][4096];
  int         rd_exp [3];
  int         wr_exp [3];
  int         cnt_max [3] = '{65535, 65535, 3};
  int         wait_n [3]  = '{2, 3, 0};

  assign data_bus = tb_oe ? tb_d : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  z80_wait_mem #(.ADDR_W(16), .DEPTH_LOG2(12), .BASE(16'h0000), .WAIT_CYCLES(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_L(rst_L), .addr_bus(addr), .data_bus(data_bus), .MREQ_L(MREQ_L),
    .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .WAIT_L(wait_l[0]), .wp(wp_v[0]),
    .rd_count(rd_a), .wr_count(wr_a), .busy(busy_w[0]));

  z80_wait_mem #(.ADDR_W(16), .DEPTH_LOG2(12), .BASE(16'h8000), .WAIT_CYCLES(3), .CNT_W(16)) u_b (
    .clk(clk), .rst_L(rst_L), .addr_bus(addr), .data_bus(data_bus), .MREQ_L(MREQ_L),
    .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .WAIT_L(wait_l[1]), .wp(wp_v[1]),
    .rd_count(rd_b), .wr_count(wr_b), .busy(busy_w[1]));

  z80_wait_mem #(.ADDR_W(16), .DEPTH_LOG2(12), .BASE(16'h4000), .WAIT_CYCLES(0), .CNT_W(2)) u_c (
    .clk(clk), .rst_L(rst_L), .addr_bus(addr), .data_bus(data_bus), .MREQ_L(MREQ_L),
    .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L), .WAIT_L(wait_l[2]), .wp(wp_v[2]),
    .rd_count(rd_c), .wr_count(wr_c), .busy(busy_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int target(input logic [15:0] a);
    case (a[15:12])
      4'h0:    return 0;
      4'h8:    return 1;
      4'h4:    return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int t);
    case (t)
      0:       return {16'h0, rd_a};
      1:       return {16'h0, rd_b};
      default: return {30'h0, rd_c};
    endcase
  endfunction

  function automatic logic [31:0] get_wr(input int t);
    case (t)
      0:       return {16'h0, wr_a};
      1:       return {16'h0, wr_b};
      default: return {30'h0, wr_c};
    endcase
  endfunction

  task automatic check_counters();
    for (int t = 0; t < 3; t++) begin
      check($sformatf("rd_count%0d", t), get_rd(t), rd_exp[t]);
      check($sformatf("wr_count%0d", t), get_wr(t), wr_exp[t]);
    end
  endtask

  task automatic bus_idle();
    MREQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; RFSH_L = 1'b1; tb_oe = 1'b0;
  endtask

  // One complete Z80 memory cycle, checked against the window/wait/data rules.
  task automatic bus_cycle(input logic [15:0] a, input bit rd, input bit wr,
                           input logic [7:0] wd, input bit rfsh);
    int t, n, lows;
    bit sel;
    logic [2:0] exp_w;
    t   = target(a);
    sel = (t >= 0) && !rfsh && (rd || wr);
    @(negedge clk);
    addr = a; MREQ_L = 1'b0; RD_L = !rd; WR_L = !wr; RFSH_L = !rfsh;
    tb_d = wd; tb_oe = wr && !rd;
    if (!sel) begin
      repeat (3) begin
        @(negedge clk);
        check("nosel_wait", wait_l, 3'b111);
        check("nosel_busy", busy_w, 3'b000);
        if (!tb_oe) check("nosel_bus", data_bus, 8'hFF);
      end
    end else begin
      n    = wait_n[t];
      lows = 0;
      for (int j = 0; j <= n + 1; j++) begin
        @(negedge clk);
        if (wait_l[t] == 1'b0) lows++;
        exp_w = (j < n) ? ~(3'b001 << t) : 3'b111;
        check("wait_l", wait_l, exp_w);
        check("busy", busy_w, 3'b001 << t);
        if (rd) check("rd_data", data_bus, (j >= n) ? mm[t][a[11:0]] : 8'hFF);
      end
      check("wait_len", lows, n);
    end
    bus_idle();
    #1 check("release_bus", data_bus, 8'hFF);
    @(negedge clk);
    check("end_busy", busy_w, 3'b000);
    check("end_wait", wait_l, 3'b111);
    if (sel) begin
      if (rd) begin
        if (rd_exp[t] < cnt_max[t]) rd_exp[t]++;
      end else if (!wp_v[t]) begin
        mm[t][a[11:0]] = wd;
        mv[t][a[11:0]] = 1'b1;
        if (wr_exp[t] < cnt_max[t]) wr_exp[t]++;
      end
    end
    check_counters();
  endtask

  function automatic logic [15:0] mk_addr(input int t, input int off);
    logic [3:0] hi;
    hi = (t == 0) ? 4'h0 : (t == 1) ? 4'h8 : 4'h4;
    return {hi, 12'(off * 12'h111 + 12'h003)};
  endfunction

  initial begin
    logic [15:0] a;
    logic [7:0]  v, nd;
    int t, r;
    for (int i = 0; i < 3; i++) begin rd_exp[i] = 0; wr_exp[i] = 0; end
    rst_L = 1'b0; addr = 16'h0; tb_d = 8'h0; wp_v = 3'b000;
    bus_idle();
    repeat (2) @(negedge clk);
    check("rst_wait", wait_l, 3'b111);
    check("rst_busy", busy_w, 3'b000);
    check("rst_bus", data_bus, 8'hFF);
    check_counters();
    rst_L = 1'b1;

    // write then read
    bus_cycle(16'h0123, 0, 1, 8'hA5, 0);
    bus_cycle(16'h0123, 1, 0, 8'h00, 0);
    check("wr_rd_a5", mm[0][12'h123], 8'hA5);

    // ROM mode
    bus_cycle(16'h0010, 0, 1, 8'h00, 0);
    wp_v[0] = 1'b1;
    bus_cycle(16'h0010, 0, 1, 8'h3C, 0);
    wp_v[0] = 1'b0;
    bus_cycle(16'h0010, 1, 0, 8'h00, 0);

    // window miss, refresh, unmapped
    bus_cycle(16'h8000, 1, 0, 8'h00, 1);
    bus_cycle(16'h2123, 1, 0, 8'h00, 0);

    // abort on instance b after one wait clock
    @(negedge clk);
    addr = 16'h8123; MREQ_L = 1'b0; RD_L = 1'b0;
    @(negedge clk);
    check("abort_wait_lo", wait_l, 3'b101);
    check("abort_bus_wait", data_bus, 8'hFF);
    bus_idle();
    @(negedge clk);
    check("abort_wait", wait_l, 3'b111);
    check("abort_busy", busy_w, 3'b000);
    check("abort_bus", data_bus, 8'hFF);
    check_counters();

    // zero-wait and saturation
    bus_cycle(16'h4005, 0, 1, 8'h5A, 0);
    repeat (5) bus_cycle(16'h4005, 1, 0, 8'h00, 0);
    check("sat_rd_c", {30'h0, rd_c}, 32'h3);

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      t = $urandom_range(0, 2);
      a = mk_addr(t, $urandom_range(0, 7));
      r = $urandom_range(0, 9);
      v = 8'($urandom_range(0, 254));
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) bus_cycle(a, 1, 0, 8'h00, 1);
        else bus_cycle({4'h2, a[11:0]}, 1, 0, 8'h00, 0);
      end else if (r <= 4 || !mv[t][a[11:0]]) begin
        wp_v[t] = ($urandom_range(0, 3) == 0);
        bus_cycle(a, 0, 1, v, 0);
        wp_v[t] = 1'b0;
      end else begin
        bus_cycle(a, 1, ($urandom_range(0, 4) == 0), v, 0);
      end
    end

    // reset mid-WAIT drops a pending write
    v  = mm[0][12'h123];
    nd = (v == 8'hAA) ? 8'h11 : (v ^ 8'h55);
    @(negedge clk);
    addr = 16'h0123; MREQ_L = 1'b0; WR_L = 1'b0; tb_d = nd; tb_oe = 1'b1;
    @(negedge clk);
    check("pre_rst_wait", wait_l, 3'b110);
    rst_L = 1'b0;
    bus_idle();
    #1;
    check("mid_rst_wait", wait_l, 3'b111);
    check("mid_rst_busy", busy_w, 3'b000);
    check("mid_rst_bus", data_bus, 8'hFF);
    for (int i = 0; i < 3; i++) begin rd_exp[i] = 0; wr_exp[i] = 0; end
    check_counters();
    @(negedge clk);
    rst_L = 1'b1;
    bus_cycle(16'h0123, 1, 0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
